debounce_timer_arbiter: RTL and testbench

DEBOUNCE_TIMER_ARBITER -- requirements
Module: debounce_timer_arbiter

---
 rtl/debounce_timer_arbiter.sv | 121 ++++++++++++
 tb/tb_debounce_timer_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_timer_arbiter.sv
// Shares one settle-window counter among NCH debouncer channels. Requesters are
// served round-robin, and timer_done_o pulses once when a full window completes.
module debounce_timer_arbiter #(
  parameter int NCH   = 5,
  parameter int TICKS = 2_000_000,
  parameter int CW    = $clog2(TICKS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] timer_reset_i,
  output logic [NCH-1:0] timer_done_o,
  output logic [NCH-1:0] grant_o,
  output logic           busy_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  win_q;
  logic [NCH-1:0] grant_q;
  logic [NCH-1:0] done_q;
  logic           busy_q;

  logic [NCH-1:0] req;
  logic           found_d;
  logic [IW-1:0]  pick_d;
  logic [IW-1:0]  ptr_d;
  logic           win_req;
  logic           last_tick;

  assign req       = ~timer_reset_i;
  assign win_req   = req[win_q];
  assign last_tick = (cnt_q == CW'(TICKS - 1));

  // Scan from ptr upward with wrap; walking the offsets downward lets the
  // lowest offset (closest to ptr) overwrite any farther candidate.
  always_comb begin
    found_d = 1'b0;
    pick_d  = ptr_q;
    for (int k = NCH - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (req[idx]) begin
        found_d = 1'b1;
        pick_d  = IW'(idx);
      end
    end
  end

  assign ptr_d = (win_q == IW'(NCH - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (found_d) begin
            state_q <= S_RUN;
            win_q   <= pick_d;
            grant_q <= NCH'(1) << pick_d;
            busy_q  <= 1'b1;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // A withdrawal outranks window completion on the same edge.
          if (!win_req) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end else if (last_tick) begin
            state_q <= S_DONE;
            done_q  <= grant_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          ptr_q   <= ptr_d;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign timer_done_o = done_q;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Directed bench for debounce_timer_arbiter with NCH=5, TICKS=4.
// Each check compares {grant_o, timer_done_o, busy_o} against a hand-derived value.
module tb_debounce_timer_arbiter;

  logic       clk;
  logic       reset;
  logic [4:0] timer_reset_i;
  logic [4:0] timer_done_o;
  logic [4:0] grant_o;
  logic       busy_o;

  int total;
  int bad;
  logic [10:0] exp_v;
  logic [10:0] got_v;

  debounce_timer_arbiter #(.NCH(5), .TICKS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .timer_reset_i (timer_reset_i),
    .timer_done_o  (timer_done_o),
    .grant_o       (grant_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    timer_reset_i = 5'b11110;
    tick;
    for (int i = 0; i < 2; i++) begin
      exp_v = {5'b00000, 5'b00000, 1'b0};
      got_v = {grant_o, timer_done_o, busy_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL reset_hold: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
      end
      tick;
    end
    timer_reset_i = 5'b11111;
    reset = 1'b0;
    tick;
  endtask

  // ch0 alone: grant next edge, done in the 5th cycle of the grant, then a gap.
  task automatic test_single;
    timer_reset_i = 5'b11110;
    tick;
    for (int c = 0; c < 4; c++) begin
      exp_v = {5'b00001, 5'b00000, 1'b1};
      got_v = {grant_o, timer_done_o, busy_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL single_run c=%0d: got g=%b d=%b b=%b want %b", c, grant_o, timer_done_o, busy_o, exp_v);
      end
      tick;
    end
    exp_v = {5'b00001, 5'b00001, 1'b1};
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL single_done: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    tick;
    exp_v = '0;
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL single_gap: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    timer_reset_i = 5'b11111;
    tick;
  endtask

  // ptr=1 here. ch2 bounces after 2 RUN cycles; then ch2+ch3 prove ptr moved to 3.
  task automatic test_bounce;
    timer_reset_i = 5'b11011;
    tick;
    tick;
    exp_v = {5'b00100, 5'b00000, 1'b1};
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL bounce_run: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    timer_reset_i = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      tick;
      exp_v = '0;
      got_v = {grant_o, timer_done_o, busy_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL bounce_abort c=%0d: got g=%b d=%b b=%b want %b", c, grant_o, timer_done_o, busy_o, exp_v);
      end
    end
    timer_reset_i = 5'b10011;
    tick;
    exp_v = {5'b01000, 5'b00000, 1'b1};
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL bounce_ptr3: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    timer_reset_i = 5'b11111;
    tick;
    tick;
  endtask

  // ptr=4 here. ch4 and ch1 hold requests: ch4 first, then ch1, no ch4 re-grant.
  task automatic test_wrap;
    logic [4:0] order [2];
    order[0] = 5'b10000;
    order[1] = 5'b00010;
    timer_reset_i = 5'b01101;
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 4; c++) begin
        tick;
        exp_v = {order[w], 5'b00000, 1'b1};
        got_v = {grant_o, timer_done_o, busy_o};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL wrap_run w=%0d c=%0d: got g=%b d=%b b=%b want %b", w, c, grant_o, timer_done_o, busy_o, exp_v);
        end
      end
      tick;
      exp_v = {order[w], order[w], 1'b1};
      got_v = {grant_o, timer_done_o, busy_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL wrap_done w=%0d: got g=%b d=%b b=%b want %b", w, grant_o, timer_done_o, busy_o, exp_v);
      end
      if (w == 1) timer_reset_i = 5'b11111;
      tick;
      exp_v = '0;
      got_v = {grant_o, timer_done_o, busy_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL wrap_gap w=%0d: got g=%b d=%b b=%b want %b", w, grant_o, timer_done_o, busy_o, exp_v);
      end
    end
  endtask

  // After reset (ptr=0): ch0, ch2, ch4 held together are served 0, 2, 4.
  task automatic test_round_robin;
    logic [4:0] order [3];
    int dones [5];
    order[0] = 5'b00001;
    order[1] = 5'b00100;
    order[2] = 5'b10000;
    for (int i = 0; i < 5; i++) dones[i] = 0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    timer_reset_i = 5'b01010;
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < 5; c++) begin
        tick;
        for (int i = 0; i < 5; i++) if (timer_done_o[i]) dones[i]++;
        exp_v = {order[w], (c == 4) ? order[w] : 5'b00000, 1'b1};
        got_v = {grant_o, timer_done_o, busy_o};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL rr_win w=%0d c=%0d: got g=%b d=%b b=%b want %b", w, c, grant_o, timer_done_o, busy_o, exp_v);
        end
      end
      if (w == 2) timer_reset_i = 5'b11111;
      tick;
      for (int i = 0; i < 5; i++) if (timer_done_o[i]) dones[i]++;
      exp_v = '0;
      got_v = {grant_o, timer_done_o, busy_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL rr_gap w=%0d: got g=%b d=%b b=%b want %b", w, grant_o, timer_done_o, busy_o, exp_v);
      end
    end
    total++;
    if (dones[0] != 1 || dones[1] != 0 || dones[2] != 1 || dones[3] != 0 || dones[4] != 1) begin
      bad++;
      $display("FAIL rr_done_count: got %0d %0d %0d %0d %0d want 1 0 1 0 1", dones[0], dones[1], dones[2], dones[3], dones[4]);
    end
  endtask

  // ptr=0 here. ch1 withdraws on the cycle its counter reads 3.
  task automatic test_collision;
    timer_reset_i = 5'b11101;
    for (int c = 0; c < 4; c++) tick;
    exp_v = {5'b00010, 5'b00000, 1'b1};
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL collide_cnt3: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    timer_reset_i = 5'b11111;
    for (int c = 0; c < 2; c++) begin
      tick;
      exp_v = '0;
      got_v = {grant_o, timer_done_o, busy_o};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL collide_abort c=%0d: got g=%b d=%b b=%b want %b", c, grant_o, timer_done_o, busy_o, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset;
    // ch1 reaches count 2, reset hits; afterwards only ch3 pending -> ch3 granted.
    timer_reset_i = 5'b11101;
    for (int c = 0; c < 3; c++) tick;
    reset = 1'b1;
    timer_reset_i = 5'b10111;
    tick;
    exp_v = '0;
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL midrst_run: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    reset = 1'b0;
    tick;
    exp_v = {5'b01000, 5'b00000, 1'b1};
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL midrst_ch3: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    // Reset on the edge where the done pulse is due: no pulse may appear.
    for (int c = 0; c < 3; c++) tick;
    reset = 1'b1;
    timer_reset_i = 5'b10101;
    tick;
    exp_v = '0;
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL midrst_done_edge: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    // ch1 and ch3 pending after release: ptr restarts at 0, so ch1 wins.
    reset = 1'b0;
    tick;
    exp_v = {5'b00010, 5'b00000, 1'b1};
    got_v = {grant_o, timer_done_o, busy_o};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL midrst_ch1_first: got g=%b d=%b b=%b want %b", grant_o, timer_done_o, busy_o, exp_v);
    end
    timer_reset_i = 5'b11111;
    tick;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    timer_reset_i = 5'b11111;
    test_reset;
    test_single;
    test_bounce;
    test_wrap;
    test_round_robin;
    test_collision;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
